pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised program-counter generator at the front of the IF stage.
- Produces the fetch address and chip-enable for instruction memory.
- Supports a configurable reset vector and PC step.
- Arbitrates jump and interrupt redirects by priority.
- Holds redirects that arrive while the stage is stalled or memory has not granted, so none are lost.

Parameters:
- ADDR_WIDTH, 32: PC width in bits.
- RESET_PC, 32'h0: first fetch address after reset.
- PC_STEP, 4: sequential increment; must be a power of two, at least 1.
- STALL_WIDTH, 6: width of the pipeline stall vector.
- STALL_BIT, 0: index of the stall bit that freezes the PC.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; asynchronous, active-high.
- stall_i  input  STALL_WIDTH  per-stage stall vector; bit STALL_BIT = STOP freezes the PC.
- fetch_gnt_i  input  1  instruction memory accepts the current pc_o this cycle.
- flush_jump_i  input  1  jump/branch redirect request.
- jump_pc_i  input  ADDR_WIDTH  jump target.
- flush_interrupt_i  input  1  interrupt/exception redirect request.
- int_pc_i  input  ADDR_WIDTH  trap vector target.
- pc_o  output  ADDR_WIDTH  current fetch address.
- ce_o  output  1  fetch enable.
- redirect_pending_o  output  1  a captured redirect is waiting to be applied.
- misalign_o  output  1  one-cycle pulse: an accepted redirect target had non-zero low bits.

Behaviour:
- One clock domain. Reset is asynchronous and active-high: rst_i high forces state RST immediately, without waiting for a clock edge.
- Reset values: pc_o = RESET_PC, ce_o = 0, redirect_pending_o = 0, misalign_o = 0, pending target = 0, pending kind = none.
- State machine, three states:
  - RST: entered on reset. On the first clk edge with rst_i low, go to BOOT.
  - BOOT: ce_o = 0, pc_o = RESET_PC. Next edge goes to RUN.
  - RUN: ce_o = 1. Stays in RUN until rst_i is asserted.
- The first RUN cycle presents RESET_PC with ce_o = 1. That is 2 edges after reset release.
- Define hold = (stall_i[STALL_BIT] == STOP) OR (fetch_gnt_i == 0). Hold is evaluated only in RUN.
- Redirect priority:
  - Incoming interrupt beats incoming jump.
  - A pending interrupt beats a new jump.
  - A new interrupt replaces any pending redirect.
  - A new jump replaces a pending jump.
- Target alignment: the accepted target has its low log2(PC_STEP) bits forced to 0.
  - misalign_o goes high on the cycle after acceptance if any of those bits were 1, otherwise low.
  - misalign_o is never high for two consecutive cycles from a single redirect.
- RUN and not hold, evaluated at each edge in this order:
  1. Selected redirect (new and/or pending, by priority) present: pc_o <= aligned target, pending cleared.
  2. Else: pc_o <= pc_o + PC_STEP, modulo 2^ADDR_WIDTH (wraps all-ones-aligned to 0, no flag).
- RUN and hold:
  - pc_o holds.
  - Any new redirect is captured into the pending register according to the priority rules.
  - redirect_pending_o = 1 from the edge after capture until the edge where it is applied.
- BOOT:
  - Redirects are captured into pending.
  - pc_o stays RESET_PC.
  - The first RUN cycle still presents RESET_PC. The pending redirect applies at the first non-hold RUN edge.
- Redirect latency: a redirect asserted in a non-hold RUN cycle appears on pc_o the next cycle. A captured redirect appears on the edge hold drops.
- Reset mid-operation: pending is discarded; all outputs take reset values asynchronously.
- Redirect inputs are sampled only when their flush bit is high; target values are don't-care otherwise.

Test Plan:
- Reset release, RESET_PC = 32'h100, gnt = 1, no stall:
  - ce_o = 0 for 1 cycle after release.
  - Then pc_o = 0x100, 0x104, 0x108 on consecutive cycles.
- Wrap-around, ADDR_WIDTH = 8, PC_STEP = 4, pc at 8'hFC, no hold:
  - next pc_o = 8'h00.
- Simultaneous redirects, no hold, jump to 0x200 and interrupt to 0x80:
  - next pc_o = 0x80.
  - misalign_o = 0.
- Capture under stall:
  - Set stall_i[0] = STOP at pc 0x40 and pulse jump to 0x300 for 1 cycle.
  - During the stall: pc_o stays 0x40 and redirect_pending_o = 1.
  - Release the stall: next pc_o = 0x300 and redirect_pending_o = 0.
- Pending priority:
  - Holding via fetch_gnt_i = 0 with a pending interrupt to 0x80, a new jump to 0x500 arrives: on release pc_o = 0x80.
  - Repeat with a pending jump to 0x500 and a new interrupt to 0x80: on release pc_o = 0x80.
- Misalign and async reset:
  - Jump to 0x203 with PC_STEP = 4 → pc_o = 0x200 and misalign_o pulses for 1 cycle.
  - Assert rst_i mid-cycle with a redirect pending → pc_o = RESET_PC, ce_o = 0 and pending = 0 before the next edge.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: IF-stage program counter with prioritised, stall-tolerant jump/interrupt redirects
module pc_gen #(
  parameter int ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4,
  parameter int STALL_WIDTH = 6,
  parameter int STALL_BIT = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [STALL_WIDTH-1:0] stall_i,
  input  logic                   fetch_gnt_i,
  input  logic                   flush_jump_i,
  input  logic [ADDR_WIDTH-1:0]  jump_pc_i,
  input  logic                   flush_interrupt_i,
  input  logic [ADDR_WIDTH-1:0]  int_pc_i,
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic                   ce_o,
  output logic                   redirect_pending_o,
  output logic                   misalign_o
);
  localparam logic STOP = 1'b1;
  localparam logic [ADDR_WIDTH-1:0] LOW = ADDR_WIDTH'(PC_STEP - 1);
  typedef enum logic [1:0] {RST, BOOT, RUN} state_t;
  typedef enum logic [1:0] {NONE, JMP, INT} kind_t;
  state_t state, state_nx;
  kind_t pend_kind, sel_kind;
  logic [ADDR_WIDTH-1:0] pend_pc, sel_pc;
  logic run, hold, take, capture, unused;
  assign unused = ^stall_i;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) state <= RST;
    else state <= state_nx;
  always_comb state_nx = state == RST ? BOOT : RUN;
  always_comb begin
    ce_o = state == RUN;
    redirect_pending_o = pend_kind != NONE;
  end
  always_comb begin
    sel_kind = flush_interrupt_i ? INT : pend_kind == INT ? INT : flush_jump_i ? JMP : pend_kind;
    sel_pc = flush_interrupt_i ? int_pc_i : pend_kind == INT ? pend_pc : flush_jump_i ? jump_pc_i : pend_pc;
    run = state == RUN;
    hold = stall_i[STALL_BIT] == STOP || !fetch_gnt_i;
    take = run && !hold;
    capture = state == BOOT || (run && hold);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      pc_o <= RESET_PC;
      pend_kind <= NONE;
      pend_pc <= '0;
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= take && sel_kind != NONE && |(sel_pc & LOW);
      if (take) begin
        pc_o <= sel_kind != NONE ? sel_pc & ~LOW : pc_o + ADDR_WIDTH'(PC_STEP);
        pend_kind <= NONE;
      end else if (capture) begin
        pend_kind <= sel_kind;
        pend_pc <= sel_pc;
      end
    end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen with a cycle model and hand-computed checkpoints
module tb_pc_gen;
  logic clk = 0, rst = 1, gnt = 1, fj = 0, fi = 0;
  logic [5:0] stall = '0;
  logic [31:0] jpc = '0, ipc = '0, pc;
  logic [7:0] pc8, jpc8, ipc8;
  logic ce, pend, mis, ce8, pend8, mis8;
  int n_chk = 0, n_fail = 0;
  assign jpc8 = jpc[7:0];
  assign ipc8 = ipc[7:0];
  always #5 clk = ~clk;
  pc_gen #(.ADDR_WIDTH(32), .RESET_PC(32'h100), .PC_STEP(4)) dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .fetch_gnt_i(gnt),
    .flush_jump_i(fj), .jump_pc_i(jpc), .flush_interrupt_i(fi), .int_pc_i(ipc),
    .pc_o(pc), .ce_o(ce), .redirect_pending_o(pend), .misalign_o(mis));
  pc_gen #(.ADDR_WIDTH(8), .RESET_PC(8'h00), .PC_STEP(4)) dut8 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .fetch_gnt_i(gnt),
    .flush_jump_i(fj), .jump_pc_i(jpc8), .flush_interrupt_i(fi), .int_pc_i(ipc8),
    .pc_o(pc8), .ce_o(ce8), .redirect_pending_o(pend8), .misalign_o(mis8));
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: cycles since release, one optional pending redirect, plain modular arithmetic
  int phase;
  bit m_pend, m_pend_int, m_mis, have, is_int, stopped;
  logic [31:0] m_tgt, m_pc, t;
  always @(posedge clk or posedge rst)
    if (rst) begin
      phase = 0; m_pend = 0; m_pend_int = 0; m_tgt = 0; m_pc = 32'h100; m_mis = 0;
    end else begin
      stopped = stall[0] || !gnt;
      have = 1; is_int = 0; t = 0;
      if (fi) begin t = ipc; is_int = 1; end
      else if (m_pend && m_pend_int) begin t = m_tgt; is_int = 1; end
      else if (fj) t = jpc;
      else if (m_pend) t = m_tgt;
      else have = 0;
      m_mis = 0;
      if (phase == 2 && !stopped) begin
        if (have) begin
          m_pc = (t / 4) * 4;
          m_mis = (t % 4) != 0;
          m_pend = 0;
        end else m_pc = m_pc + 4;
      end else if ((phase == 1 || phase == 2) && have) begin
        m_pend = 1; m_pend_int = is_int; m_tgt = t;
      end
      if (phase < 2) phase++;
    end
  always @(negedge clk) begin
    check("model_pc", pc, m_pc);
    check("model_pc8", {24'h0, pc8}, {24'h0, m_pc[7:0]});
    check("model_ce", {31'h0, ce}, {31'h0, phase == 2 && !rst});
    check("model_pend", {31'h0, pend}, {31'h0, m_pend});
    check("model_mis", {31'h0, mis}, {31'h0, m_mis});
    check("model_ce8", {29'h0, ce8, pend8, mis8}, {29'h0, ce, pend, mis});
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  initial begin
    step; step;
    rst = 0;
    step; check("boot_ce", {31'h0, ce}, 0); check("boot_pc", pc, 32'h100);
    step; check("run0_ce", {31'h0, ce}, 1); check("run0_pc", pc, 32'h100);
    step; check("run1_pc", pc, 32'h104);
    step; check("run2_pc", pc, 32'h108);
    fj = 1; jpc = 32'hFC;
    step; fj = 0; check("jmp_fc", pc, 32'hFC); check("jmp_fc8", {24'h0, pc8}, 32'hFC);
    step; check("wrap8", {24'h0, pc8}, 32'h00); check("nowrap32", pc, 32'h100);
    fj = 1; jpc = 32'h200; fi = 1; ipc = 32'h80;
    step; fj = 0; fi = 0; check("both_pc", pc, 32'h80); check("both_mis", {31'h0, mis}, 0);
    fj = 1; jpc = 32'h40;
    step; fj = 0; check("to40", pc, 32'h40);
    stall[0] = 1; fj = 1; jpc = 32'h300;
    step; fj = 0; check("stall_pc", pc, 32'h40); check("stall_pend", {31'h0, pend}, 1);
    step; check("stall_pc2", pc, 32'h40); check("stall_pend2", {31'h0, pend}, 1);
    stall[0] = 0;
    step; check("rel_pc", pc, 32'h300); check("rel_pend", {31'h0, pend}, 0);
    gnt = 0; fi = 1; ipc = 32'h80;
    step; fi = 0; fj = 1; jpc = 32'h500;
    step; fj = 0; gnt = 1;
    step; check("pint_pc", pc, 32'h80); check("pint_pend", {31'h0, pend}, 0);
    step; check("adv84", pc, 32'h84);
    gnt = 0; fj = 1; jpc = 32'h500;
    step; fj = 0; fi = 1; ipc = 32'h80;
    step; fi = 0; gnt = 1;
    step; check("pjmp_pc", pc, 32'h80);
    fj = 1; jpc = 32'h203;
    step; fj = 0; check("mis_pc", pc, 32'h200); check("mis_hi", {31'h0, mis}, 1);
    step; check("mis_lo", {31'h0, mis}, 0); check("mis_adv", pc, 32'h204);
    gnt = 0; fj = 1; jpc = 32'h600;
    step; fj = 0; check("pre_rst_pend", {31'h0, pend}, 1);
    #2 rst = 1;
    #1 check("arst_pc", pc, 32'h100); check("arst_ce", {31'h0, ce}, 0);
    check("arst_pend", {31'h0, pend}, 0); check("arst_mis", {31'h0, mis}, 0);
    gnt = 1;
    step; rst = 0;
    step; step; check("rerun_pc", pc, 32'h100); check("rerun_ce", {31'h0, ce}, 1);
    step; check("discard_pc", pc, 32'h104);
    step;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
